// File: rtl/mrnaiso_ctrl_pkg.sv
// Shared types and constants for the mRNA isolation bank valve sequencer:
// phase codes, the 13-line valve vector, per-phase valve maps and the pump pattern.
package mrnaiso_ctrl_pkg;

   typedef enum logic [3:0] {
      PH_IDLE       = 4'd0,
      PH_LOAD_CELLS = 4'd1,
      PH_LOAD_LYSIS = 4'd2,
      PH_LOAD_BEADS = 4'd3,
      PH_MIX        = 4'd4,
      PH_SEPARATE   = 4'd5,
      PH_WASH       = 4'd6,
      PH_COLLECT    = 4'd7,
      PH_GAP        = 4'd8,
      PH_DONE       = 4'd9,
      PH_ABORT      = 4'd10
   } phase_e;

   typedef struct packed {
      logic cells_in;
      logic cells_out;
      logic sieve;
      logic lysis_in;
      logic lysis_out;
      logic beads;
      logic pump1;
      logic pump2;
      logic pump3;
      logic sep;
      logic push;
      logic waste;
      logic collect;
   } valve_t;

   localparam valve_t VALVES_OFF     = valve_t'(13'b0000000000000);
   localparam valve_t VALVES_CELLS   = valve_t'(13'b1110000000000);
   localparam valve_t VALVES_LYSIS   = valve_t'(13'b0001100000000);
   localparam valve_t VALVES_BEADS   = valve_t'(13'b0000010000000);
   localparam valve_t VALVES_SEP     = valve_t'(13'b0000000001000);
   localparam valve_t VALVES_WASH    = valve_t'(13'b0000000001110);
   localparam valve_t VALVES_COLLECT = valve_t'(13'b0000000001101);

   // Index 0 is the first step; bits are {pump1, pump2, pump3}.
   localparam logic [5:0][2:0] PUMP_PATTERN =
      {3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};

   function automatic int unsigned at_least_one(input int unsigned v);
      return (v == 0) ? 1 : v;
   endfunction

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Counters run 0..max-1, so $clog2(max) bits suffice (min 1 bit).
   function automatic int unsigned cnt_width(input int unsigned max_value);
      return (max_value > 1) ? $clog2(max_value) : 1;
   endfunction

   // Pump lines are driven separately by the pump sub-module.
   function automatic valve_t valve_map(input logic [3:0] ph);
      case (phase_e'(ph))
         PH_LOAD_CELLS: return VALVES_CELLS;
         PH_LOAD_LYSIS: return VALVES_LYSIS;
         PH_LOAD_BEADS: return VALVES_BEADS;
         PH_SEPARATE:   return VALVES_SEP;
         PH_WASH:       return VALVES_WASH;
         PH_COLLECT:    return VALVES_COLLECT;
         default:       return VALVES_OFF;
      endcase
   endfunction

endpackage

// File: rtl/mrnaiso_peristaltic_pump.sv
// Three-valve peristaltic pump stepper: walks the 6-step pattern while enabled,
// counting ticks per step and full pattern cycles; output is registered.
module mrnaiso_peristaltic_pump
   import mrnaiso_ctrl_pkg::*;
#(
   parameter int unsigned PUMP_STEP_TICKS = 2,
   parameter int unsigned MIX_CYCLES      = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       tick,
   output logic [2:0] pattern,
   output logic       cycles_done
);

   localparam int unsigned STEP_T = at_least_one(PUMP_STEP_TICKS);
   localparam int unsigned CYC    = at_least_one(MIX_CYCLES);
   localparam int unsigned SW     = cnt_width(STEP_T);
   localparam int unsigned CW     = cnt_width(CYC);
   localparam logic [SW-1:0] SUB_LAST = SW'(STEP_T - 1);
   localparam logic [CW-1:0] CYC_LAST = CW'(CYC - 1);

   logic [SW-1:0] sub_reg, sub_next;
   logic [2:0]    step_reg, step_next;
   logic [CW-1:0] cyc_reg, cyc_next;
   logic [2:0]    pattern_reg, pattern_next;
   logic          step_end;

   assign step_end    = tick && (sub_reg == SUB_LAST);
   assign cycles_done = step_end && (step_reg == 3'd5) && (cyc_reg == CYC_LAST);
   assign pattern     = pattern_reg;

   // 'enable' reflects the upcoming state, so the registered pattern lines up
   // with the sequencer's registered phase without a one-cycle lag.
   always_comb begin
      sub_next  = sub_reg;
      step_next = step_reg;
      cyc_next  = cyc_reg;
      if (!enable) begin
         sub_next  = '0;
         step_next = 3'd0;
         cyc_next  = '0;
      end else if (tick) begin
         if (step_end) begin
            sub_next = '0;
            if (step_reg == 3'd5) begin
               step_next = 3'd0;
               if (cyc_reg != CYC_LAST) cyc_next = cyc_reg + CW'(1);
            end else begin
               step_next = step_reg + 3'd1;
            end
         end else begin
            sub_next = sub_reg + SW'(1);
         end
      end
      pattern_next = enable ? PUMP_PATTERN[step_next] : 3'b000;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sub_reg     <= '0;
         step_reg    <= 3'd0;
         cyc_reg     <= '0;
         pattern_reg <= 3'b000;
      end else begin
         sub_reg     <= sub_next;
         step_reg    <= step_next;
         cyc_reg     <= cyc_next;
         pattern_reg <= pattern_next;
      end
   end

endmodule

// File: rtl/mrnaiso_valve_sequencer.sv
// Protocol sequencer for the mRNA isolation bank: FSM, tick prescaler and phase
// timer, with every valve and status output registered from the next state.
module mrnaiso_valve_sequencer
   import mrnaiso_ctrl_pkg::*;
#(
   parameter int unsigned TICK_DIV        = 1000,
   parameter int unsigned CELLS_TICKS     = 50,
   parameter int unsigned LYSIS_TICKS     = 50,
   parameter int unsigned BEADS_TICKS     = 50,
   parameter int unsigned PUMP_STEP_TICKS = 2,
   parameter int unsigned MIX_CYCLES      = 20,
   parameter int unsigned SEP_TICKS       = 100,
   parameter int unsigned WASH_TICKS      = 50,
   parameter int unsigned COLLECT_TICKS   = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   output logic       busy,
   output logic       done,
   output logic       aborted,
   output logic [3:0] phase,
   output logic       cells_in_ctrl,
   output logic       cells_out_ctrl,
   output logic       sieve_ctrl,
   output logic       lysis_in_ctrl,
   output logic       lysis_out_ctrl,
   output logic       beads_ctrl,
   output logic       pump1,
   output logic       pump2,
   output logic       pump3,
   output logic       sep_ctrl,
   output logic       push_ctrl,
   output logic       waste_ctrl,
   output logic       collect_ctrl
);

   localparam logic [3:0] S_IDLE       = PH_IDLE;
   localparam logic [3:0] S_LOAD_CELLS = PH_LOAD_CELLS;
   localparam logic [3:0] S_LOAD_LYSIS = PH_LOAD_LYSIS;
   localparam logic [3:0] S_LOAD_BEADS = PH_LOAD_BEADS;
   localparam logic [3:0] S_MIX        = PH_MIX;
   localparam logic [3:0] S_SEPARATE   = PH_SEPARATE;
   localparam logic [3:0] S_WASH       = PH_WASH;
   localparam logic [3:0] S_COLLECT    = PH_COLLECT;
   localparam logic [3:0] S_GAP        = PH_GAP;
   localparam logic [3:0] S_DONE       = PH_DONE;
   localparam logic [3:0] S_ABORT      = PH_ABORT;

   localparam int unsigned DIV     = at_least_one(TICK_DIV);
   localparam int unsigned D_CELLS = at_least_one(CELLS_TICKS);
   localparam int unsigned D_LYSIS = at_least_one(LYSIS_TICKS);
   localparam int unsigned D_BEADS = at_least_one(BEADS_TICKS);
   localparam int unsigned D_SEP   = at_least_one(SEP_TICKS);
   localparam int unsigned D_WASH  = at_least_one(WASH_TICKS);
   localparam int unsigned D_COLL  = at_least_one(COLLECT_TICKS);
   localparam int unsigned MAX_D   =
      max2(max2(max2(D_CELLS, D_LYSIS), max2(D_BEADS, D_SEP)), max2(D_WASH, D_COLL));
   localparam int unsigned PW = cnt_width(DIV);
   localparam int unsigned TW = cnt_width(MAX_D);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   logic [3:0]    state_reg, state_next;
   logic [3:0]    follow_reg, follow_next;
   logic [PW-1:0] presc_reg, presc_next;
   logic [TW-1:0] timer_reg, timer_next;
   logic [TW-1:0] phase_last;
   valve_t        valve_reg;
   logic          busy_reg, done_reg, aborted_reg;
   logic          timed, tick, phase_end, mix_done;
   logic [2:0]    pump_pattern;

   assign timed = (state_reg >= S_LOAD_CELLS) && (state_reg <= S_COLLECT);
   assign tick  = timed && (presc_reg == PRESC_LAST);

   always_comb begin
      case (state_reg)
         S_LOAD_CELLS: phase_last = TW'(D_CELLS - 1);
         S_LOAD_LYSIS: phase_last = TW'(D_LYSIS - 1);
         S_LOAD_BEADS: phase_last = TW'(D_BEADS - 1);
         S_SEPARATE:   phase_last = TW'(D_SEP - 1);
         S_WASH:       phase_last = TW'(D_WASH - 1);
         S_COLLECT:    phase_last = TW'(D_COLL - 1);
         default:      phase_last = '0;
      endcase
   end

   assign phase_end = (state_reg == S_MIX) ? mix_done
                                           : (tick && (timer_reg == phase_last));

   always_comb begin
      state_next  = state_reg;
      follow_next = follow_reg;
      case (state_reg)
         S_IDLE:         if (start && !abort) state_next = S_LOAD_CELLS;
         S_GAP:          state_next = abort ? S_ABORT : follow_reg;
         S_DONE, S_ABORT: state_next = S_IDLE;
         S_LOAD_CELLS, S_LOAD_LYSIS, S_LOAD_BEADS, S_MIX,
         S_SEPARATE, S_WASH, S_COLLECT: begin
            if (abort) begin
               state_next = S_ABORT;
            end else if (phase_end) begin
               state_next = (state_reg == S_COLLECT) ? S_DONE : S_GAP;
               // Protocol phases have consecutive codes, so the successor is +1.
               follow_next = state_reg + 4'd1;
            end
         end
         default:        state_next = S_IDLE;
      endcase

      if ((state_next != state_reg) || !timed || tick) presc_next = '0;
      else                                             presc_next = presc_reg + PW'(1);

      if (state_next != state_reg)           timer_next = '0;
      else if (tick && (state_reg != S_MIX)) timer_next = timer_reg + TW'(1);
      else                                   timer_next = timer_reg;
   end

   mrnaiso_peristaltic_pump #(
      .PUMP_STEP_TICKS (PUMP_STEP_TICKS),
      .MIX_CYCLES      (MIX_CYCLES)
   ) u_pump (
      .clk         (clk),
      .rst         (rst),
      .enable      (state_next == S_MIX),
      .tick        (tick),
      .pattern     (pump_pattern),
      .cycles_done (mix_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         follow_reg  <= S_IDLE;
         presc_reg   <= '0;
         timer_reg   <= '0;
         valve_reg   <= VALVES_OFF;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         aborted_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         follow_reg  <= follow_next;
         presc_reg   <= presc_next;
         timer_reg   <= timer_next;
         valve_reg   <= valve_map(state_next);
         busy_reg    <= (state_next >= S_LOAD_CELLS) && (state_next <= S_GAP);
         done_reg    <= (state_next == S_DONE);
         aborted_reg <= (state_next == S_ABORT);
      end
   end

   assign phase          = state_reg;
   assign busy           = busy_reg;
   assign done           = done_reg;
   assign aborted        = aborted_reg;
   assign cells_in_ctrl  = valve_reg.cells_in;
   assign cells_out_ctrl = valve_reg.cells_out;
   assign sieve_ctrl     = valve_reg.sieve;
   assign lysis_in_ctrl  = valve_reg.lysis_in;
   assign lysis_out_ctrl = valve_reg.lysis_out;
   assign beads_ctrl     = valve_reg.beads;
   assign pump1          = pump_pattern[2];
   assign pump2          = pump_pattern[1];
   assign pump3          = pump_pattern[0];
   assign sep_ctrl       = valve_reg.sep;
   assign push_ctrl      = valve_reg.push;
   assign waste_ctrl     = valve_reg.waste;
   assign collect_ctrl   = valve_reg.collect;

endmodule

// File: doc/mrnaiso_valve_sequencer.md
Name: mrnaiso_valve_sequencer

Overview:
Electronic control-side driver for the mRNA isolation bank. It generates every control line the bank consumes: cells, lysis, beads, sieve, separation, push, waste, collect and the three-valve peristaltic pump. It steps one full isolation protocol per start command, using parameterised phase durations. It sits between the host/test controller and the pneumatic solenoid drivers that feed the bank's control ports. There is one sequencer per bank; all SIZE lanes share the same control lines.

Parameters:
- TICK_DIV, 1000: clock cycles per protocol tick (prescaler); must be ≥1.
- CELLS_TICKS, 50: LOAD_CELLS duration in ticks.
- LYSIS_TICKS, 50: LOAD_LYSIS duration in ticks.
- BEADS_TICKS, 50: LOAD_BEADS duration in ticks.
- PUMP_STEP_TICKS, 2: ticks per peristaltic pump step.
- MIX_CYCLES, 20: number of full 6-step pump cycles in MIX.
- SEP_TICKS, 100: SEPARATE duration in ticks.
- WASH_TICKS, 50: WASH duration in ticks.
- COLLECT_TICKS, 50: COLLECT duration in ticks.
- Any duration or count parameter set to 0 is treated as 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  level-sampled start request; acted on only in IDLE
- abort  in  1  immediate abort; all valves close
- busy  out  1  high from the first protocol phase until DONE/ABORT exit
- done  out  1  one-cycle pulse when COLLECT completes
- aborted  out  1  one-cycle pulse when an abort is taken
- phase  out  4  current state encoding (see Behaviour)
- cells_in_ctrl, cells_out_ctrl, sieve_ctrl, lysis_in_ctrl, lysis_out_ctrl, beads_ctrl, pump1, pump2, pump3, sep_ctrl, push_ctrl, waste_ctrl, collect_ctrl  out  1 each  valve drive; 1 = actuated open

Behaviour:
- Reset:
  - Async reset drives every output to 0 and puts the block in IDLE (phase = 0).
  - Prescaler, phase timer and pump counters all clear.
- Registered outputs: all outputs are registered. Valve outputs are a pure function of registered state; there is no combinational path from input to output.
- States and phase codes: IDLE=0, LOAD_CELLS=1, LOAD_LYSIS=2, LOAD_BEADS=3, MIX=4, SEPARATE=5, WASH=6, COLLECT=7, GAP=8, DONE=9, ABORT=10.
- Valve map (all lines not listed are 0):
  - LOAD_CELLS: cells_in, cells_out, sieve.
  - LOAD_LYSIS: lysis_in, lysis_out.
  - LOAD_BEADS: beads.
  - MIX: pump pattern only.
  - SEPARATE: sep.
  - WASH: sep, push, waste.
  - COLLECT: sep, push, collect.
  - IDLE, GAP, DONE, ABORT: all valves 0.
- Start:
  - When IDLE and start=1 (and abort=0) on edge N, the block enters LOAD_CELLS at edge N+1.
  - busy=1 from that same edge.
- Break-before-make: between consecutive protocol phases there is exactly one GAP cycle with all valves closed.
- Timing:
  - The prescaler restarts at each phase entry; a tick fires every TICK_DIV cycles.
  - A phase of D ticks therefore occupies exactly D×TICK_DIV cycles.
- MIX pump pattern:
  - 6 steps, (pump1,pump2,pump3) = 100, 110, 010, 011, 001, 101.
  - Each step lasts PUMP_STEP_TICKS ticks; the step index wraps 5→0.
  - MIX exits after MIX_CYCLES full wraps.
- Completion:
  - After COLLECT the block enters DONE for 1 cycle: done=1, busy=0, then returns to IDLE.
  - If start is still high it is accepted again from IDLE on the next cycle.
- Abort:
  - abort=1 in any non-IDLE state gives: next edge ABORT (all valves 0, aborted=1, busy=0), then IDLE.
  - Abort in IDLE is ignored.
  - Simultaneous start and abort in IDLE: stay IDLE, no pulse.
- Ignored inputs: start while busy, DONE or ABORT is ignored; there is no queueing.
- Counters:
  - Counters are sized by $clog2 of their maximum value.
  - No counter wrap is reachable with legal parameters.

Decomposition:
- Package mrnaiso_ctrl_pkg holds:
  - the phase_e enum (codes above);
  - the valve-vector struct (13 bits) and per-phase valve-map constants;
  - the 6-entry pump pattern constant.
- Sub-module mrnaiso_peristaltic_pump:
  - inputs: enable, tick;
  - outputs: the pump1..3 pattern and cycles_done;
  - contains the step counter and cycle counter.
- The top level holds the FSM, prescaler and phase timer.

Test Plan:
- Full run: TICK_DIV=4, all durations 2, PUMP_STEP_TICKS=1, MIX_CYCLES=1; start pulsed at cycle 0.
  - LOAD_CELLS spans cycles 1–8.
  - 6 GAP cycles, each with all valves 0.
  - done pulses exactly at cycle 79; busy low from cycle 79.
- Pump pattern: during MIX, pump1..3 step 100→110→010→011→001→101, each held 4 cycles; no other valve is high.
- Abort mid-MIX (step 3): the next edge gives all valves 0, aborted=1, phase=10; the edge after that gives phase=0. done never pulses.
- Async reset asserted mid-WASH, between clock edges: all outputs go to 0 immediately. After release, start is still required to begin a run.
- Start held high: after done, the run restarts one cycle after DONE. start=1 with abort=1 in IDLE produces no state change.
- Zero-duration parameters (SEP_TICKS=0): SEPARATE lasts exactly TICK_DIV cycles.
